// File: rtl/snake_stream_feeder.sv
// Serpentine feature-map streamer: reads a multi-channel map from local SRAM and
// feeds the PE array through a 2-entry FIFO, with optional zero border and backpressure.
module snake_stream_feeder #(
  parameter int CH        = 4,
  parameter int DW        = 8,
  parameter int OUT_LANES = 32,
  parameter int MAX_DIM   = 256,
  parameter int AW        = $clog2(MAX_DIM*MAX_DIM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(MAX_DIM):0]     cfg_rows,
  input  logic [$clog2(MAX_DIM):0]     cfg_cols,
  input  logic [2:0]                   cfg_k,
  input  logic                         cfg_pad,
  output logic                         mem_re,
  output logic [AW-1:0]                mem_addr,
  input  logic [CH*DW-1:0]             mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_LANES*DW-1:0]      data_out,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);
  localparam int CW = $clog2(MAX_DIM) + 1;
  localparam int PW = CH*DW;

  typedef enum logic [1:0] {S_IDLE, S_PRO, S_BODY, S_DRAIN} state_t;
  state_t r_state, w_state_nx;

  logic [CW-1:0] r_cols, r_sr, r_sc, r_klast;
  logic          r_pad;
  logic [CW-1:0] r_row, r_col;
  logic          r_rl;
  logic [PW-1:0] r_fifo [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;
  logic          r_pend;

  logic [CW:0]   w_sr_new, w_sc_new;
  logic          w_legal;
  logic          w_active, w_border, w_pop, w_room, w_issue, w_zero, w_push;
  logic [2:0]    w_slots;
  logic          w_row_end, w_pro_last, w_line_end, w_body_last;
  logic [CW-1:0] w_srow, w_scol;
  logic [2*CW-1:0] w_addr;

  assign w_sr_new = (CW+1)'(cfg_rows) + (CW+1)'({cfg_pad, 1'b0});
  assign w_sc_new = (CW+1)'(cfg_cols) + (CW+1)'({cfg_pad, 1'b0});
  assign w_legal  = (cfg_rows != '0) && (cfg_rows <= CW'(MAX_DIM)) &&
                    (cfg_cols != '0) && (cfg_cols <= CW'(MAX_DIM)) &&
                    (cfg_k >= 3'd2) &&
                    ((CW+1)'(cfg_k) - (CW+1)'(1) <= w_sr_new);

  assign out_valid = (r_cnt != 2'd0);
  assign w_pop     = out_valid & out_ready & ~abort;
  // A pop in the same cycle frees a slot, which keeps the stream at 1 pixel/cycle.
  assign w_slots   = 3'(r_cnt) + 3'(r_pend) - 3'(w_pop);
  assign w_room    = (w_slots < 3'd2);

  assign w_border  = r_pad & ((r_row == '0) || (r_row == r_sr - CW'(1)) ||
                              (r_col == '0) || (r_col == r_sc - CW'(1)));
  assign w_active  = ((r_state == S_PRO) || (r_state == S_BODY)) & ~abort;
  // Zero pixels wait for an in-flight read so FIFO order matches issue order.
  assign w_issue   = w_active & w_room & ~(w_border & r_pend);
  assign mem_re    = w_issue & ~w_border;
  assign w_zero    = w_issue & w_border;
  assign w_push    = ~abort & (r_pend | w_zero);

  assign w_srow    = r_row - CW'(r_pad);
  assign w_scol    = r_col - CW'(r_pad);
  assign w_addr    = (2*CW)'(w_srow) * (2*CW)'(r_cols) + (2*CW)'(w_scol);
  assign mem_addr  = mem_re ? AW'(w_addr) : '0;

  assign w_row_end   = (r_row == r_klast);
  assign w_pro_last  = w_row_end && (r_col == r_sc - CW'(1));
  assign w_line_end  = r_rl ? (r_col == '0) : (r_col == r_sc - CW'(1));
  assign w_body_last = w_line_end && (r_row == r_sr - CW'(1));

  assign busy     = (r_state != S_IDLE);
  assign data_out = out_valid ? (OUT_LANES*DW)'(r_fifo[r_rp]) : '0;

  always_comb begin
    w_state_nx = r_state;
    cfg_err    = 1'b0;
    done       = 1'b0;
    if (abort) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (w_legal) w_state_nx = S_PRO;
          else         cfg_err    = 1'b1;
        end
        S_PRO:  if (w_issue && w_pro_last)
          w_state_nx = (r_sr == r_klast + CW'(1)) ? S_DRAIN : S_BODY;
        S_BODY: if (w_issue && w_body_last) w_state_nx = S_DRAIN;
        S_DRAIN: if ((r_cnt == 2'd0) && !r_pend) begin
          done       = 1'b1;
          w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cols  <= '0;
      r_sr    <= '0;
      r_sc    <= '0;
      r_klast <= '0;
      r_pad   <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_rl    <= 1'b0;
    end else if (!abort && (r_state == S_IDLE) && start && w_legal) begin
      r_cols  <= cfg_cols;
      r_sr    <= CW'(w_sr_new);
      r_sc    <= CW'(w_sc_new);
      r_klast <= CW'(cfg_k) - CW'(2);
      r_pad   <= cfg_pad;
      r_row   <= '0;
      r_col   <= '0;
      r_rl    <= 1'b1;
    end else if (w_issue) begin
      if (r_state == S_PRO) begin
        if (w_pro_last) begin
          r_row <= r_klast + CW'(1);
          r_rl  <= 1'b1;
        end else if (w_row_end) begin
          r_row <= '0;
          r_col <= r_col + CW'(1);
        end else begin
          r_row <= r_row + CW'(1);
        end
      end else if (w_line_end) begin
        // The next row starts at the column where this one ended.
        r_row <= r_row + CW'(1);
        r_rl  <= ~r_rl;
      end else begin
        r_col <= r_rl ? r_col - CW'(1) : r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
      r_pend <= 1'b0;
    end else if (abort) begin
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= mem_re;
      if (w_push) begin
        r_fifo[r_wp] <= r_pend ? mem_rdata : '0;
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_snake_stream_feeder.sv
// Randomised self-checking bench for snake_stream_feeder: a coordinate-list model
// predicts every beat and every SRAM address of each scan.
module tb_snake_stream_feeder;
  logic         clk = 1'b0;
  logic         rst_n, start, abort, cfg_pad, mem_re, out_valid, out_ready;
  logic         busy, done, cfg_err;
  logic [8:0]   cfg_rows, cfg_cols;
  logic [2:0]   cfg_k;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic [255:0] data_out;

  snake_stream_feeder #(.CH(4), .DW(8), .OUT_LANES(32), .MAX_DIM(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_k(cfg_k), .cfg_pad(cfg_pad),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cur_c = 1;
  int cyc = 0, n_beats, n_memre = 0, n_busy, n_done, n_cfgerr, first_valid_cyc, last_hs_cyc;
  int exp_total;
  bit done_seen, prev_stall = 0;
  logic [255:0] prev_data;
  logic [255:0] exp_q[$];
  logic [15:0]  addr_q[$];

  logic [7:0] s1_lit [16] = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13,
                              8'h23, 8'h22, 8'h21, 8'h20, 8'h30, 8'h31, 8'h32, 8'h33};
  logic [7:0] k4_lit [15] = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h21, 8'h02, 8'h12,
                              8'h22, 8'h32, 8'h31, 8'h30, 8'h40, 8'h41, 8'h42};

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int r, input int c);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(r*16 + c);
    b1 = 8'(r*7 + c);
    b2 = 8'(c + 'h30);
    b3 = 8'(r ^ 'h5A);
    return {b3, b2, b1, b0};
  endfunction

  // SRAM: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= pix(int'(mem_addr) / cur_c, int'(mem_addr) % cur_c);
    else        mem_rdata <= $urandom;
  end

  task automatic add(input int r, input int c, input int C, input int P, input int SR, input int SC);
    if (P != 0 && (r == 0 || c == 0 || r == SR-1 || c == SC-1)) begin
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(256'(pix(r-P, c-P)));
      addr_q.push_back(16'((r-P)*C + (c-P)));
    end
  endtask

  task automatic build(input int R, input int C, input int K, input int P);
    int SR, SC;
    SR = R + 2*P;
    SC = C + 2*P;
    exp_q.delete();
    addr_q.delete();
    for (int c = 0; c < SC; c++)
      for (int r = 0; r <= K-2; r++) add(r, c, C, P, SR, SC);
    for (int r = K-1; r < SR; r++) begin
      if (((r - (K-1)) % 2) == 0) for (int c = SC-1; c >= 0; c--) add(r, c, C, P, SR, SC);
      else                        for (int c = 0; c < SC; c++)    add(r, c, C, P, SR, SC);
    end
    exp_total = exp_q.size();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (start && !busy) cyc = 0;
      else cyc++;
      if (busy) n_busy++;
      if (cfg_err) n_cfgerr++;
      if (mem_re) begin
        n_memre++;
        if (addr_q.size() == 0) chk("extra_mem_re", 256'(mem_addr), '1);
        else chk("mem_addr", 256'(mem_addr), 256'(addr_q.pop_front()));
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        chk("hold_valid", 256'(out_valid), 256'(1));
        chk("hold_data", data_out, prev_data);
      end
      if (out_valid && out_ready) begin
        n_beats++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_beat", data_out, '1);
        else chk("beat", data_out, exp_q.pop_front());
      end
      if (done) begin
        done_seen = 1;
        n_done++;
        chk("done_at", 256'(cyc), 256'(last_hs_cyc + 1));
        chk("beats_left", 256'(exp_q.size()), 256'(0));
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = data_out;
    end
  end

  task automatic run_scan(input int R, input int C, input int K, input int P,
                          input bit bp, input int abort_at, input int bstart_at);
    bit aborted, bs;
    aborted = 0;
    bs = 0;
    cur_c = C;
    done_seen = 0;
    n_done = 0;
    n_beats = 0;
    n_busy = 0;
    first_valid_cyc = -1;
    cfg_rows = 9'(R);
    cfg_cols = 9'(C);
    cfg_k    = 3'(K);
    cfg_pad  = 1'(P);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 3000 && !done_seen && !aborted; t++) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_k = 3'(K);
      if (abort_at > 0 && n_beats == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b0;
        aborted = 1;
      end else if (bstart_at > 0 && n_beats == bstart_at && !bs) begin
        start = 1'b1;
        cfg_k = 3'd1;
        bs = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
    end
    if (aborted) begin
      chk("abort_valid", 256'(out_valid), 256'(0));
      chk("abort_busy", 256'(busy), 256'(0));
      chk("abort_done", 256'(done), 256'(0));
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", 256'(n_done), 256'(0));
      chk("abort_quiet", 256'(out_valid), 256'(0));
      exp_q.delete();
      addr_q.delete();
    end else begin
      chk("scan_done", 256'(done_seen), 256'(1));
      repeat (2) @(posedge clk);
      #1;
      chk("beats", 256'(n_beats), 256'(exp_total));
      chk("done_count", 256'(n_done), 256'(1));
    end
  endtask

  task automatic try_bad(input int R, input int C, input int K, input int P);
    int m0;
    m0 = n_memre;
    n_cfgerr = 0;
    n_busy = 0;
    cfg_rows = 9'(R);
    cfg_cols = 9'(C);
    cfg_k    = 3'(K);
    cfg_pad  = 1'(P);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bad_cfg_err", 256'(n_cfgerr), 256'(1));
    chk("bad_busy", 256'(n_busy), 256'(0));
    chk("bad_mem_re", 256'(n_memre - m0), 256'(0));
  endtask

  initial begin
    int R, C, K, P, m0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_k = '0; cfg_pad = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_re", 256'(mem_re), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_data", data_out, '0);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_cfg_err", 256'(cfg_err), 256'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    build(4, 4, 3, 0);
    for (int i = 0; i < 16; i++) chk("s1_model", 256'(exp_q[i][7:0]), 256'(s1_lit[i]));
    run_scan(4, 4, 3, 0, 0, 0, 0);
    chk("s1_latency", 256'(first_valid_cyc), 256'(3));
    chk("s1_busy_cycles", 256'(n_busy), 256'(19));

    build(4, 4, 3, 0);
    n_cfgerr = 0;
    run_scan(4, 4, 3, 0, 1, 0, 3);
    chk("start_while_busy_err", 256'(n_cfgerr), 256'(0));

    build(2, 2, 3, 1);
    chk("pad_model_00", exp_q[3], 256'(32'h5A300000));
    chk("pad_model_01", exp_q[5], 256'(32'h5A310101));
    chk("pad_model_11", exp_q[9], 256'(32'h5B310811));
    chk("pad_model_10", exp_q[10], 256'(32'h5B300710));
    chk("pad_model_reads", 256'(addr_q.size()), 256'(4));
    m0 = n_memre;
    run_scan(2, 2, 3, 1, 0, 0, 0);
    chk("pad_latency", 256'(first_valid_cyc), 256'(2));
    chk("pad_mem_re_count", 256'(n_memre - m0), 256'(4));

    build(5, 3, 4, 0);
    for (int i = 0; i < 15; i++) chk("k4_model", 256'(exp_q[i][7:0]), 256'(k4_lit[i]));
    run_scan(5, 3, 4, 0, 1, 0, 0);

    build(2, 3, 3, 0);
    chk("sr_eq_k1_model", 256'(exp_total), 256'(6));
    run_scan(2, 3, 3, 0, 0, 0, 0);

    build(4, 4, 3, 0);
    run_scan(4, 4, 3, 0, 0, 5, 0);
    build(4, 4, 3, 0);
    run_scan(4, 4, 3, 0, 0, 0, 0);

    try_bad(4, 4, 1, 0);
    try_bad(0, 4, 3, 0);
    try_bad(3, 4, 5, 0);

    build(4, 4, 3, 0);
    cur_c = 4;
    cfg_rows = 9'd4; cfg_cols = 9'd4; cfg_k = 3'd3; cfg_pad = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mem_re", 256'(mem_re), 256'(0));
    chk("arst_mem_addr", 256'(mem_addr), 256'(0));
    chk("arst_valid", 256'(out_valid), 256'(0));
    chk("arst_data", data_out, '0);
    chk("arst_busy", 256'(busy), 256'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      R = $urandom_range(1, 6);
      C = $urandom_range(1, 6);
      P = $urandom_range(0, 1);
      K = $urandom_range(2, (R + 2*P + 1 > 7) ? 7 : R + 2*P + 1);
      build(R, C, K, P);
      chk("rand_model_size", 256'(exp_total), 256'((R + 2*P) * (C + 2*P)));
      run_scan(R, C, K, P, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/snake_stream_feeder.md
Name: snake_stream_feeder

Overview:
- Generalised on-chip successor to the bench-side DRAM stimulus.
- Reads a multi-channel input feature map from a local buffer SRAM and streams it to the PE array in serpentine order.
- Order: a column-interleaved prologue over the first K-1 rows, then alternating right-to-left / left-to-right full rows.
- Generalised over channel count, runtime map size, kernel height, optional zero-padding border and output backpressure.

Parameters:
- CH, 4, input channels packed per pixel word.
- DW, 8, bits per channel sample.
- OUT_LANES, 32, byte lanes on data_out; must be >= CH; lanes above CH are driven zero.
- MAX_DIM, 256, maximum rows/cols of the stored (unpadded) map.
- AW, clog2(MAX_DIM*MAX_DIM), SRAM word address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a scan when idle
- abort  in  1  synchronous flush to IDLE
- cfg_rows  in  clog2(MAX_DIM)+1  stored map rows R
- cfg_cols  in  clog2(MAX_DIM)+1  stored map cols C
- cfg_k  in  3  kernel height K; legal 2..7
- cfg_pad  in  1  1 = emit one-pixel zero border (scan size R+2 x C+2)
- mem_re  out  1  SRAM read enable
- mem_addr  out  AW  word address = row*C + col of the stored map
- mem_rdata  in  CH*DW  read data, valid exactly 1 cycle after mem_re
- out_valid  out  1  data_out holds a pixel
- out_ready  in  1  consumer accepts when out_valid & out_ready
- data_out  out  OUT_LANES*DW  {zeros, pixel}; pixel in bits [CH*DW-1:0], channel 0 in the LSB byte
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse in the cycle after the last pixel handshake
- cfg_err  out  1  one-cycle pulse when start carries an illegal config

Behaviour:
- Reset values: mem_re=0, mem_addr=0, out_valid=0, data_out=0, busy=0, done=0, cfg_err=0. The FIFO is emptied and the FSM is in IDLE.
- Scan geometry: scan rows SR = R+2*pad and scan cols SC = C+2*pad. Scan coordinate (r,c) maps to stored (r-pad, c-pad).
- Legality: 1<=R<=MAX_DIM, 1<=C<=MAX_DIM, 2<=K<=7 and K-1<=SR.
  - Illegal config on start: pulse cfg_err, stay IDLE, set no busy.
- FSM states: IDLE, PRO, BODY, DRAIN.
  - IDLE -> PRO on a legal start. busy rises the next cycle.
  - PRO: for c = 0..SC-1, for r = 0..K-2, emit (r,c).
  - PRO -> BODY after (K-2, SC-1) is issued. If SR = K-1, PRO -> DRAIN instead.
  - BODY: for r = K-1..SR-1. If (r-(K-1)) is even, emit c = SC-1 down to 0; otherwise c = 0 up to SC-1.
  - BODY -> DRAIN after (SR-1, last col) is issued.
  - DRAIN: wait until the FIFO is empty and no read is outstanding. Then pulse done, drop busy and go to IDLE.
  - K=3, pad=0 reproduces the existing order: (0,0),(1,0),(0,1),(1,1),...,(1,C-1),(2,C-1)..(2,0),(3,0)..(3,C-1),...
- Issue rules:
  - One coordinate is issued per cycle, only when FIFO occupancy + outstanding reads < 2.
  - A border coordinate (pad=1 and r or c on the scan edge) issues no mem_re. It pushes an all-zero pixel the same cycle.
  - An interior coordinate asserts mem_re. Its rdata is pushed one cycle later.
  - Pushes into the 2-entry output FIFO occur in issue order. A zero push never overtakes an outstanding read: zero issue is stalled while a read is outstanding.
- Output:
  - out_valid = FIFO not empty; data_out = FIFO head.
  - Pop on handshake. A simultaneous push and pop keeps occupancy.
  - With out_ready held high, throughput is 1 pixel/cycle. First-pixel latency from start is 3 cycles for a memory pixel and 2 cycles for a pad pixel.
- Backpressure: out_valid and data_out hold stable while out_ready=0. No pixel is dropped or duplicated.
- Simultaneous events:
  - start while busy is ignored, with no cfg_err.
  - abort has priority over start and over any push or issue.
- Abort behaviour: the next cycle sees FIFO empty, out_valid=0, IDLE, busy=0 and no done. Any read returning after the abort is discarded.
- Asynchronous reset mid-scan returns all outputs to their reset values immediately.
- Total handshakes per scan = SR*SC.

Test Plan:
- R=C=4, K=3, pad=0, out_ready=1, map value = row*16+col: 16 beats in order 00,10,01,11,02,12,03,13,23,22,21,20,30,31,32,33. done pulses one cycle after the 16th beat. busy is high for 19 cycles.
- Same config with out_ready toggled by random 50% backpressure: identical 16-beat sequence, data_out stable while stalled, mem_re never issued with 2 entries pending.
- R=C=2, K=3, pad=1: 16 beats on a 4x4 scan. Only scan positions (1,1),(1,2),(2,1),(2,2) are nonzero, carrying stored 00,01,10,11. mem_re is asserted exactly 4 times.
- R=5, C=3, K=4, pad=0: prologue 00,10,20,01,11,21,02,12,22, then row 3 right-to-left (32,31,30) and row 4 left-to-right (40,41,42). 15 beats total.
- Abort after the 5th beat of the first scenario: out_valid=0 and busy=0 the next cycle, no done pulse. A new start replays the sequence from 00.
- start with K=1, then with R=0, then with K=5 and R=3 (pad=0): cfg_err pulses each time, busy stays 0, no mem_re.
